// File: rtl/mips_pkg.sv
// Shared fetch-stage types and widths for the MIPS pipeline front end.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_redirect.sv
// Instruction fetch with IF/ID register, one-word skid buffer for stalls and
// branch redirect that drains a request already on the instruction bus.
module fetch_redirect
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               B_taken,
  input  logic [ADDR_W-1:0]  br_addr,
  input  logic               freeze,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               flush
);

  fetch_state_t       state_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  tgt_reg;
  logic [INSTR_W-1:0] skid_reg;
  logic               req_reg;
  logic               if_valid_reg;
  logic [ADDR_W-1:0]  if_pc_reg;
  logic [INSTR_W-1:0] if_instr_reg;

  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  br_target;
  logic               accept;

  assign pc_plus4  = pc_reg + ADDR_W'(4);
  assign br_target = align_word(br_addr);
  // A word is only taken when this block actually has a request on the bus.
  assign accept    = req_reg & imem_ready;

  // pc_reg keeps the outstanding address while draining, so imem_addr is
  // simply pc_reg in every requesting state.
  assign imem_req  = req_reg;
  assign imem_addr = pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_pc     = if_pc_reg;
  assign if_instr  = if_instr_reg;
  assign flush     = B_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      tgt_reg      <= '0;
      skid_reg     <= '0;
      req_reg      <= 1'b0;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= '0;
      if_instr_reg <= '0;
    end else begin
      req_reg <= 1'b1;
      case (state_reg)
        FETCH: begin
          if (B_taken) begin
            if_valid_reg <= 1'b0;
            // With no live request there is nothing to drain.
            if (accept || !req_reg) begin
              pc_reg <= br_target;
            end else begin
              tgt_reg   <= br_target;
              state_reg <= DRAIN;
            end
          end else if (accept) begin
            if (freeze) begin
              skid_reg  <= imem_rdata;
              state_reg <= HOLD;
              req_reg   <= 1'b0;
            end else begin
              if_pc_reg    <= pc_plus4;
              if_instr_reg <= imem_rdata;
              if_valid_reg <= 1'b1;
              pc_reg       <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (B_taken) begin
            skid_reg     <= '0;
            if_valid_reg <= 1'b0;
            pc_reg       <= br_target;
            state_reg    <= FETCH;
          end else if (!freeze) begin
            if_pc_reg    <= pc_plus4;
            if_instr_reg <= skid_reg;
            if_valid_reg <= 1'b1;
            pc_reg       <= pc_plus4;
            state_reg    <= FETCH;
          end else begin
            req_reg <= 1'b0;
          end
        end
        DRAIN: begin
          if (B_taken) begin
            tgt_reg      <= br_target;
            if_valid_reg <= 1'b0;
          end
          if (imem_ready) begin
            pc_reg    <= B_taken ? br_target : tgt_reg;
            state_reg <= FETCH;
          end
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Randomized and directed checks of fetch_redirect against a behavioural
// model of the fetch rules (pc, skid word, pending redirect, IF/ID contents).
module tb_fetch_redirect;

  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_taken;
  logic [31:0] br_addr;
  logic        freeze;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;

  logic        w_rst_n;
  logic        w_ready;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_flush;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Memory model: every returned word is its address xor KEY.
  assign imem_rdata   = imem_addr ^ KEY;
  assign w_imem_rdata = w_imem_addr ^ KEY;

  fetch_redirect dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .B_taken    (b_taken),
    .br_addr    (br_addr),
    .freeze     (freeze),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .flush      (flush)
  );

  fetch_redirect #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .B_taken    (1'b0),
    .br_addr    (32'h0),
    .freeze     (1'b0),
    .imem_req   (w_imem_req),
    .imem_addr  (w_imem_addr),
    .imem_ready (w_ready),
    .imem_rdata (w_imem_rdata),
    .if_valid   (w_if_valid),
    .if_pc      (w_if_pc),
    .if_instr   (w_if_instr),
    .flush      (w_flush)
  );

  // Reference model state
  logic [31:0] m_pc, m_tgt, m_skid, m_if_pc, m_if_instr;
  bit          m_started, m_has_skid, m_drain, m_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input logic [31:0] pc0);
    m_pc = pc0; m_tgt = '0; m_skid = '0; m_if_pc = '0; m_if_instr = '0;
    m_started = 0; m_has_skid = 0; m_drain = 0; m_valid = 0;
  endtask

  task automatic model_deliver(input logic [31:0] word);
    m_if_pc    = m_pc + 32'd4;
    m_if_instr = word;
    m_valid    = 1;
    m_pc       = m_pc + 32'd4;
  endtask

  task automatic model_step(input bit b, input logic [31:0] ba, input bit frz, input bit rdy);
    logic [31:0] t;
    t = {ba[31:2], 2'b00};
    if (m_has_skid) begin
      if (b) begin
        m_has_skid = 0; m_valid = 0; m_pc = t;
      end else if (!frz) begin
        model_deliver(m_skid);
        m_has_skid = 0;
      end
    end else if (m_drain) begin
      if (b) begin m_tgt = t; m_valid = 0; end
      if (rdy) begin m_pc = m_tgt; m_drain = 0; end
    end else if (b) begin
      m_valid = 0;
      if (rdy || !m_started) m_pc = t;
      else begin m_tgt = t; m_drain = 1; end
    end else if (rdy && m_started) begin
      if (frz) begin m_skid = m_pc ^ KEY; m_has_skid = 1; end
      else model_deliver(m_pc ^ KEY);
    end
    m_started = 1;
  endtask

  // One clock cycle on the main instance: drive, check flush, advance model, compare.
  task automatic cycle(input bit b, input logic [31:0] ba, input bit frz, input bit rdy);
    bit exp_req;
    b_taken = b; br_addr = ba; freeze = frz; imem_ready = rdy;
    #1;
    check_eq("flush", {31'b0, flush}, {31'b0, b});
    model_step(b, ba, frz, rdy);
    @(posedge clk);
    #1;
    cyc++;
    exp_req = m_started && !m_has_skid;
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    check_eq("if_pc", if_pc, m_if_pc);
    check_eq("if_instr", if_instr, m_if_instr);
    $display("cyc %0d b=%0b ba=%h frz=%0b rdy=%0b -> req=%0b addr=%h v=%0b if_pc=%h if_instr=%h",
             cyc, b, ba, frz, rdy, imem_req, imem_addr, if_valid, if_pc, if_instr);
  endtask

  task automatic reset_outputs_zero(input string tag);
    check_eq({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    check_eq({tag, "_addr"}, imem_addr, 32'h0);
    check_eq({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
    check_eq({tag, "_if_pc"}, if_pc, 32'h0);
    check_eq({tag, "_if_instr"}, if_instr, 32'h0);
    check_eq({tag, "_flush"}, {31'b0, flush}, 32'h0);
  endtask

  task automatic apply_reset();
    b_taken = 0; br_addr = '0; freeze = 0; imem_ready = 0;
    rst_n = 0;
    #1;
    reset_outputs_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset(32'h0);
  endtask

  initial begin
    rst_n = 1; w_rst_n = 1; w_ready = 0;
    b_taken = 0; br_addr = '0; freeze = 0; imem_ready = 0;
    #1;
    rst_n = 0; w_rst_n = 0;
    #1;
    // Asynchronous reset takes effect before any clock edge.
    reset_outputs_zero("por");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset(32'h0);

    // Streaming fetch: first request appears one edge after release.
    cycle(0, 0, 0, 1);
    check_eq("first_req", {31'b0, imem_req}, 32'h1);
    check_eq("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1);
      check_eq("seq_if_pc", if_pc, 32'(4 * (i + 1)));
      check_eq("seq_if_instr", if_instr, 32'(4 * i) ^ KEY);
    end

    // Freeze for three cycles with the memory answering: word goes to skid.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1);
      check_eq("hold_req", {31'b0, imem_req}, 32'h0);
      check_eq("hold_if_pc", if_pc, 32'h18);
    end
    cycle(0, 0, 0, 1);
    check_eq("skid_if_instr", if_instr, 32'h18 ^ KEY);
    check_eq("skid_if_pc", if_pc, 32'h1C);
    check_eq("skid_next_addr", imem_addr, 32'h1C);

    // Branch while the request at 0x10 is stalled.
    apply_reset();
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check_eq("stall_addr", imem_addr, 32'h10);
    cycle(1, 32'h0000_0103, 0, 0);
    check_eq("drain_addr", imem_addr, 32'h10);
    check_eq("drain_valid", {31'b0, if_valid}, 32'h0);
    cycle(0, 0, 0, 0);
    check_eq("drain_hold_addr", imem_addr, 32'h10);
    cycle(0, 0, 0, 1);
    check_eq("redirect_addr", imem_addr, 32'h100);
    check_eq("redirect_valid", {31'b0, if_valid}, 32'h0);

    // Branch together with freeze while holding a skid word.
    cycle(0, 0, 1, 1);
    check_eq("hold2_req", {31'b0, imem_req}, 32'h0);
    cycle(1, 32'h0000_0203, 1, 0);
    check_eq("hold_br_addr", imem_addr, 32'h200);
    check_eq("hold_br_req", {31'b0, imem_req}, 32'h1);
    check_eq("hold_br_valid", {31'b0, if_valid}, 32'h0);

    // Asynchronous reset in the middle of a drain.
    cycle(1, 32'h0000_0300, 0, 0);
    check_eq("pre_rst_drain_addr", imem_addr, 32'h200);
    b_taken = 0;
    #2;
    rst_n = 0;
    #1;
    reset_outputs_zero("drain_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset(32'h0);
    cycle(0, 0, 0, 0);
    check_eq("post_rst_req", {31'b0, imem_req}, 32'h1);
    check_eq("post_rst_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 1);
    check_eq("post_rst_valid", {31'b0, if_valid}, 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1);
    end

    // PC wrap-around on the instance reset to 0xFFFF_FFFC.
    w_rst_n = 1;
    @(posedge clk);
    #1;
    check_eq("wrap_req", {31'b0, w_imem_req}, 32'h1);
    check_eq("wrap_addr", w_imem_addr, WRAP_PC);
    w_ready = 1;
    @(posedge clk);
    #1;
    check_eq("wrap_if_pc", w_if_pc, 32'h0);
    check_eq("wrap_if_valid", {31'b0, w_if_valid}, 32'h1);
    check_eq("wrap_if_instr", w_if_instr, WRAP_PC ^ KEY);
    check_eq("wrap_next_addr", w_imem_addr, 32'h0);
    check_eq("wrap_flush", {31'b0, w_flush}, 32'h0);
    w_ready = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
